// File: rtl/csa_resolve_cpa_pkg.sv
// -----------------------------------------------------------------------------
// csa_resolve_cpa_pkg
//   Shared definitions for the digit-serial carry-propagate resolver:
//   FSM state encoding and the chunk-counter width helper.
// -----------------------------------------------------------------------------
package csa_resolve_cpa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit
    // so that the NCHUNK=1 configuration still has a legal counter.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csa_resolve_cpa_cpa_chunk.sv
// -----------------------------------------------------------------------------
// full_adder / cpa_chunk
//   full_adder : single-bit full adder cell.
//     i_a, i_b, i_cin : addend bits and carry-in
//     o_s, o_cout     : sum bit and carry-out
//   cpa_chunk  : CHUNK-bit combinational ripple adder built from full_adder.
//     i_a, i_b [CHUNK] : addend chunks
//     i_cin            : carry into bit 0
//     o_s [CHUNK]      : chunk sum
//     o_cout           : carry out of the top bit
// -----------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module cpa_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);
    logic [CHUNK:0] carry;

    assign carry[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (carry[i]),
            .o_s    (o_s[i]),
            .o_cout (carry[i+1])
        );
    end

    assign o_cout = carry[CHUNK];
endmodule

// File: rtl/csa_resolve_cpa.sv
// -----------------------------------------------------------------------------
// csa_resolve_cpa
//   Resolves a redundant (carry, sum) pair from a carry-save reducer into a
//   binary result, CHUNK bits per cycle, with a registered inter-chunk carry.
//   The carry vector arrives already shifted; no internal alignment is done.
//
// Ports
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_valid : input pair presented        o_ready : pair can be accepted (IDLE)
//   i_c     : carry vector [WIDTH]        i_s     : sum vector [WIDTH]
//   o_valid : result available (DONE)     i_ready : downstream takes result
//   o_sum   : (i_c + i_s) mod 2^WIDTH     o_cout  : bit WIDTH of i_c + i_s
// -----------------------------------------------------------------------------
module csa_resolve_cpa
    import csa_resolve_cpa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_s,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("csa_resolve_cpa: WIDTH must be a multiple of CHUNK");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;        // carry operand, shifted right per chunk
    logic [WIDTH-1:0]   b_q;        // sum operand, shifted right per chunk
    logic [WIDTH-1:0]   acc_q;      // result built up from the MSB side
    logic [WIDTH-1:0]   sum_q;      // published result, only written on DONE entry
    logic               carry_q;    // inter-chunk carry
    logic               cout_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [CHUNK-1:0]   chunk_s;
    logic               chunk_cout;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_d;

    cpa_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a    (a_q[CHUNK-1:0]),
        .i_b    (b_q[CHUNK-1:0]),
        .i_cin  (carry_q),
        .o_s    (chunk_s),
        .o_cout (chunk_cout)
    );

    // After NCHUNK shifts the first chunk resolved sits in the LSBs. Shifting
    // the concatenation (rather than slicing acc_q) keeps CHUNK == WIDTH legal.
    always_comb begin
        acc_d = WIDTH'({chunk_s, acc_q} >> CHUNK);
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
    end

    // NOTE: every register here is assigned with <= so all of them sample the
    // pre-edge values; blocking assignments would let later statements see
    // already-updated state and silently change the shift/carry sequencing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_c;
                        b_q     <= i_s;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    acc_q   <= acc_d;
                    carry_q <= chunk_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= acc_d;
                        cout_q  <= chunk_cout;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags decode state only, so neither i_valid nor i_ready has a
    // combinational path to any output.
    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;

endmodule
